// File: rtl/intr_entry_ctrl.sv
// Interrupt-entry sequencer: drains the pipe, flushes front-end registers, pushes the return PC
// and redirects fetch to the vector. Optional macro IRQ_SYNC_EN adds a 2-flop irq synchronizer.
module intr_entry_ctrl #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      VEC_ADDR = 8'h01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            pipe_busy,
  input  logic            rti_retire,
  input  logic            stk_gnt,
  output logic            stall_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            int_signal,
  output logic            stk_req,
  output logic [PC_W-1:0] stk_wdata,
  output logic            pc_load_vec,
  output logic [PC_W-1:0] vec_addr,
  output logic            in_isr,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    FLUSH  = 3'd2,
    PUSH   = 3'd3,
    VECTOR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              in_isr_q, in_isr_d;
  logic [PC_W-1:0]   stk_wdata_q, stk_wdata_d;
  logic              irq_q;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_q = sync2_q;
`else
  assign irq_q = irq;
`endif

  // Stack push handshake: stk_req stays high with stk_wdata stable until a cycle in which
  // stk_gnt is also high; that rising edge completes the push (same-cycle grant accepted).
  always_comb begin
    state_d     = state_q;
    in_isr_d    = in_isr_q;
    stk_wdata_d = stk_wdata_q;
    unique case (state_q)
      // An RTI retiring this cycle unmasks immediately so a held irq re-enters next cycle.
      IDLE:    if (irq_q && (!in_isr_q || rti_retire)) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = FLUSH;
      FLUSH: begin
        stk_wdata_d = pc_cur;
        state_d     = PUSH;
      end
      PUSH:    if (stk_gnt) state_d = VECTOR;
      VECTOR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rti_retire) in_isr_d = 1'b0;
    if (state_q == VECTOR) in_isr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_isr_q    <= 1'b0;
      stk_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      in_isr_q    <= in_isr_d;
      stk_wdata_q <= stk_wdata_d;
    end
  end

  always_comb begin
    stall_pc    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    int_signal  = 1'b0;
    stk_req     = 1'b0;
    pc_load_vec = 1'b0;
    unique case (state_q)
      IDLE:   ;
      DRAIN:  stall_pc = 1'b1;
      FLUSH: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        int_signal  = 1'b1;
      end
      PUSH: begin
        stall_pc = 1'b1;
        stk_req  = 1'b1;
      end
      VECTOR: pc_load_vec = 1'b1;
      default: ;
    endcase
  end

  assign stk_wdata = stk_wdata_q;
  assign in_isr    = in_isr_q;
  assign vec_addr  = VEC_ADDR;
  assign dbg_state = state_q;

endmodule
